date_counter: RTL and testbench

DATE_COUNTER -- requirements
Module: date_counter

---
 rtl/date_pkg.sv | 21 ++
 rtl/month_len.sv | 20 ++
 rtl/date_counter.sv | 99 +++++++++
 tb/tb_date_counter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/date_pkg.sv
// Shared widths, limits and reset date for the calendar date counter.
package date_pkg;

    localparam int YEAR_W  = 7;
    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;

    localparam logic [YEAR_W-1:0]  YEAR_MAX  = 7'd99;
    localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;

    // Reset date is 2000-01-01; year is an offset from 2000.
    localparam logic [YEAR_W-1:0]  RST_YEAR  = 7'd0;
    localparam logic [MONTH_W-1:0] RST_MONTH = 4'd1;
    localparam logic [DAY_W-1:0]   RST_DAY   = 5'd1;

    // Divisible-by-four is exact across 2000..2099 (2000 itself is a leap year).
    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        return (y[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/month_len.sv
// Combinational month length lookup: number of days in a month given leap status.
module month_len
    import date_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic               leap,
    output logic [DAY_W-1:0]   length
);

    // Thirty days hath September, April, June and November; February depends on leap.
    always_comb begin
        length = 5'd31;
        case (month)
            4'd2:                    length = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: length = 5'd30;
            default:                 length = 5'd31;
        endcase
    end

endmodule

// File: rtl/date_counter.sv
// Calendar date register (years 2000..2099). Advances one day on each midnight
// pulse in run mode; in set mode the selected field is stepped up or down with
// wrap, and a year/month change clamps the day to the new month length.
module date_counter
    import date_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_date_en,
    input  logic               set_year_en,
    input  logic               set_month_en,
    input  logic               set_day_en,
    input  logic               set_inc,
    input  logic               set_dec,
    input  logic               day_carry,
    output logic [YEAR_W-1:0]  year,
    output logic [MONTH_W-1:0] month,
    output logic [DAY_W-1:0]   day,
    output logic               leap_year,
    output logic               month_last_day
);

    logic [DAY_W-1:0]   cur_len;
    logic [DAY_W-1:0]   nxt_len;
    logic [YEAR_W-1:0]  year_nxt;
    logic [MONTH_W-1:0] month_nxt;
    logic [DAY_W-1:0]   day_pre;
    logic [DAY_W-1:0]   day_nxt;
    logic               leap_nxt;

    assign leap_year      = is_leap(year);
    assign leap_nxt       = is_leap(year_nxt);
    assign month_last_day = (day == cur_len);

    // Length of the month currently held in the registers.
    month_len u_len_cur (
        .month  (month),
        .leap   (leap_year),
        .length (cur_len)
    );

    // Length of the month the date is about to become; used for day clamping.
    month_len u_len_nxt (
        .month  (month_nxt),
        .leap   (leap_nxt),
        .length (nxt_len)
    );

    // Next-date computation: run-mode rollover or set-mode field step.
    always_comb begin
        year_nxt  = year;
        month_nxt = month;
        day_pre   = day;
        if (!set_date_en) begin
            if (day_carry) begin
                if (day == cur_len) begin
                    day_pre = DAY_W'(1);
                    if (month == MONTH_MAX) begin
                        month_nxt = MONTH_W'(1);
                        year_nxt  = (year == YEAR_MAX) ? '0 : year + YEAR_W'(1);
                    end else begin
                        month_nxt = month + MONTH_W'(1);
                    end
                end else begin
                    day_pre = day + DAY_W'(1);
                end
            end
        end else if (set_inc != set_dec) begin
            // Exactly one direction requested; year beats month beats day.
            if (set_year_en) begin
                if (set_inc) year_nxt = (year == YEAR_MAX) ? '0 : year + YEAR_W'(1);
                else         year_nxt = (year == '0) ? YEAR_MAX : year - YEAR_W'(1);
            end else if (set_month_en) begin
                if (set_inc) month_nxt = (month == MONTH_MAX) ? MONTH_W'(1) : month + MONTH_W'(1);
                else         month_nxt = (month == MONTH_W'(1)) ? MONTH_MAX : month - MONTH_W'(1);
            end else if (set_day_en) begin
                if (set_inc) day_pre = (day == cur_len) ? DAY_W'(1) : day + DAY_W'(1);
                else         day_pre = (day == DAY_W'(1)) ? cur_len : day - DAY_W'(1);
            end
        end
        // Clamping is applied unconditionally: only a year/month change can
        // leave day_pre beyond the new month length, so other paths pass through.
        day_nxt = (day_pre > nxt_len) ? nxt_len : day_pre;
    end

    // Date registers with asynchronous reset to 2000-01-01.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            year  <= RST_YEAR;
            month <= RST_MONTH;
            day   <= RST_DAY;
        end else begin
            year  <= year_nxt;
            month <= month_nxt;
            day   <= day_nxt;
        end
    end

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: a driver applies one cycle of stimulus and
// pushes the hand-computed date; a monitor pops and compares on the falling edge.
module tb_date_counter;

    logic       clk;
    logic       rst_n;
    logic       set_date_en;
    logic       set_year_en;
    logic       set_month_en;
    logic       set_day_en;
    logic       set_inc;
    logic       set_dec;
    logic       day_carry;
    logic [6:0] year;
    logic [3:0] month;
    logic [4:0] day;
    logic       leap_year;
    logic       month_last_day;

    // Packed expectation: {year[6:0], month[3:0], day[4:0], leap, last}
    logic [17:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    date_counter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .set_date_en    (set_date_en),
        .set_year_en    (set_year_en),
        .set_month_en   (set_month_en),
        .set_day_en     (set_day_en),
        .set_inc        (set_inc),
        .set_dec        (set_dec),
        .day_carry      (day_carry),
        .year           (year),
        .month          (month),
        .day            (day),
        .leap_year      (leap_year),
        .month_last_day (month_last_day)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] pk(input int y, input int m, input int d,
                                       input bit l, input bit e);
        logic [17:0] r;
        r = {7'(y), 4'(m), 5'(d), l, e};
        return r;
    endfunction

    task automatic push(input string nm, input int y, input int m, input int d,
                        input bit l, input bit e);
        exp_q.push_back(pk(y, m, d, l, e));
        name_q.push_back(nm);
    endtask

    task automatic clear_inputs();
        set_date_en  = 1'b0;
        set_year_en  = 1'b0;
        set_month_en = 1'b0;
        set_day_en   = 1'b0;
        set_inc      = 1'b0;
        set_dec      = 1'b0;
        day_carry    = 1'b0;
    endtask

    // One clock of stimulus followed by the expected date after that edge.
    task automatic step(input string nm, input bit sde, input bit ys, input bit ms,
                        input bit ds, input bit inc, input bit dec, input bit dc,
                        input int y, input int m, input int d, input bit l, input bit e);
        @(negedge clk);
        #1;
        set_date_en  = sde;
        set_year_en  = ys;
        set_month_en = ms;
        set_day_en   = ds;
        set_inc      = inc;
        set_dec      = dec;
        day_carry    = dc;
        @(posedge clk);
        #1;
        clear_inputs();
        push(nm, y, m, d, l, e);
    endtask

    // Assert reset between edges with whatever inputs are currently driven.
    task automatic do_reset(input string nm);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        push(nm, 0, 1, 1, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        clear_inputs();
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT date against the oldest expectation.
    always @(negedge clk) begin
        logic [17:0] got;
        logic [17:0] exp;
        string       nm;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {year, month, day, leap_year, month_last_day};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %0d-%0d-%0d leap=%0b last=%0b, required %0d-%0d-%0d leap=%0b last=%0b",
                         nm, got[17:11], got[10:7], got[6:2], got[1], got[0],
                         exp[17:11], exp[10:7], exp[6:2], exp[1], exp[0]);
            end
        end
    end

    // Stimulus
    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #1;
        push("reset_hold", 0, 1, 1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Run mode basics
        //   name           sde ys ms ds inc dec dc   y   m   d  l  e
        step("run_advance",  0, 0, 0, 0, 0, 0, 1,   0,  1,  2, 1, 0);
        step("run_ign_inc",  0, 1, 0, 0, 1, 0, 0,   0,  1,  2, 1, 0);
        step("run_ign_dec",  0, 0, 0, 1, 0, 1, 0,   0,  1,  2, 1, 0);
        step("run_advance2", 0, 0, 0, 0, 0, 0, 1,   0,  1,  3, 1, 0);

        // Mid-run asynchronous reset with a midnight pulse in flight
        @(negedge clk);
        #1;
        day_carry = 1'b1;
        do_reset("reset_mid_run");

        // Leap February 2000
        step("set_mon_inc",  1, 0, 1, 0, 1, 0, 0,   0,  2,  1, 1, 0);
        step("set_day_wrap", 1, 0, 0, 1, 0, 1, 0,   0,  2, 29, 1, 1);
        step("set_day_dec",  1, 0, 0, 1, 0, 1, 0,   0,  2, 28, 1, 0);
        step("leap_28_29",   0, 0, 0, 0, 0, 0, 1,   0,  2, 29, 1, 1);
        step("leap_29_0301", 0, 0, 0, 0, 0, 0, 1,   0,  3,  1, 1, 0);

        // Non-leap February 2001
        step("set_mon_dec",  1, 0, 1, 0, 0, 1, 0,   0,  2,  1, 1, 0);
        step("set_yr_inc",   1, 1, 0, 0, 1, 0, 0,   1,  2,  1, 0, 0);
        step("set_day_wrp2", 1, 0, 0, 1, 0, 1, 0,   1,  2, 28, 0, 1);
        step("nonleap_0301", 0, 0, 0, 0, 0, 0, 1,   1,  3,  1, 0, 0);

        // Century wrap from 2099-12-31
        do_reset("reset_idle");
        step("set_yr_wrap",  1, 1, 0, 0, 0, 1, 0,  99,  1,  1, 0, 0);
        step("set_mon_wrap", 1, 0, 1, 0, 0, 1, 0,  99, 12,  1, 0, 0);
        step("set_day_to31", 1, 0, 0, 1, 0, 1, 0,  99, 12, 31, 0, 1);
        step("century_wrap", 0, 0, 0, 0, 0, 0, 1,   0,  1,  1, 1, 0);

        // Clamp on month change, no clamp on year change
        step("set_yr_0001",  1, 1, 0, 0, 1, 0, 0,   1,  1,  1, 0, 0);
        step("set_day_0131", 1, 0, 0, 1, 0, 1, 0,   1,  1, 31, 0, 1);
        step("clamp_month",  1, 0, 1, 0, 1, 0, 0,   1,  2, 28, 0, 1);
        step("yr_dec_noclp", 1, 1, 0, 0, 0, 1, 0,   0,  2, 28, 1, 0);

        // Set-mode guards
        step("set_ign_carry",1, 0, 0, 0, 0, 0, 1,   0,  2, 28, 1, 0);
        step("set_carry_sel",1, 0, 0, 1, 0, 0, 1,   0,  2, 28, 1, 0);
        step("inc_and_dec",  1, 1, 0, 0, 1, 1, 0,   0,  2, 28, 1, 0);
        step("no_select",    1, 0, 0, 0, 1, 0, 0,   0,  2, 28, 1, 0);
        step("prio_year",    1, 1, 1, 1, 1, 0, 0,   1,  2, 28, 0, 1);
        step("prio_month",   1, 0, 1, 1, 0, 1, 0,   1,  1, 28, 0, 0);
        step("clamp_to_leap",1, 1, 0, 0, 0, 1, 0,   0,  1, 28, 1, 0);

        // Day decrement wrap in April; held increment acts once per clock
        do_reset("reset_idle2");
        step("mon_to_02",    1, 0, 1, 0, 1, 0, 0,   0,  2,  1, 1, 0);
        step("mon_to_03",    1, 0, 1, 0, 1, 0, 0,   0,  3,  1, 1, 0);
        step("mon_to_04",    1, 0, 1, 0, 1, 0, 0,   0,  4,  1, 1, 0);
        step("apr_day_wrap", 1, 0, 0, 1, 0, 1, 0,   0,  4, 30, 1, 1);
        step("apr_inc_wrap", 1, 0, 0, 1, 1, 0, 0,   0,  4,  1, 1, 0);
        step("held_inc_1",   1, 0, 0, 1, 1, 0, 0,   0,  4,  2, 1, 0);
        step("held_inc_2",   1, 0, 0, 1, 1, 0, 0,   0,  4,  3, 1, 0);
        step("mon_inc_wrap", 1, 0, 1, 0, 1, 0, 0,   0,  5,  3, 1, 0);
        step("set_yr_99",    1, 1, 0, 0, 0, 1, 0,  99,  5,  3, 0, 0);
        step("set_yr_inc99", 1, 1, 0, 0, 1, 0, 0,   0,  5,  3, 1, 0);

        // Reset in the middle of a set operation
        @(negedge clk);
        #1;
        set_date_en = 1'b1;
        set_year_en = 1'b1;
        set_inc     = 1'b1;
        do_reset("reset_mid_set");
        step("after_reset",  0, 0, 0, 0, 0, 0, 1,   0,  1,  2, 1, 0);

        // Drain: every pushed expectation must have been consumed
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
